// File: rtl/capture_sequencer.sv
// capture_sequencer: arms on request, captures 2^ADDR_W samples into a buffer, then drains them over a valid/ready stream. Optional threshold trigger via CAPTURE_TRIG_EN.
module capture_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              Fg_CLK,
   input  logic              RESET,
   input  logic              Ready,
   input  logic              Enable,
   input  logic [3:0]        Mode,
   input  logic [DATA_W-1:0] Sample,
   input  logic              Arm,
   input  logic              Abort,
   input  logic [DATA_W-1:0] Threshold,
   output logic              Busy,
   output logic              Done,
   output logic [3:0]        Cap_mode,
   output logic              Out_valid,
   input  logic              Out_ready,
   output logic [DATA_W-1:0] Out_data,
   output logic              Out_last
);
   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DRAIN} state_t;
`ifdef CAPTURE_TRIG_EN
   localparam state_t ARM_STATE = WAIT_TRIG;
`else
   localparam state_t ARM_STATE = CAPTURE;
`endif
   state_t state, state_nxt;
   logic primed, arm_ok, we, xfer, wr_last, trig, done_nxt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   assign arm_ok    = Arm & primed;
   assign wr_last   = &wr_ptr;
   assign Busy      = state != IDLE;
   assign Out_valid = state == DRAIN;
   assign Out_last  = Out_valid & (&rd_ptr);
   assign Out_data  = Out_valid ? mem[rd_ptr] : '0;
   assign xfer      = Out_valid & Out_ready;
`ifdef CAPTURE_TRIG_EN
   logic [DATA_W-1:0] prev;
   logic prev_valid;
   assign trig = Enable & prev_valid & (prev < Threshold) & (Sample >= Threshold);
   // remembers the previous sample seen while waiting for an upward threshold crossing
   always_ff @(posedge Fg_CLK) begin
      if (RESET) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (state == IDLE) begin
         prev_valid <= 1'b0;
      end else if (state == WAIT_TRIG && Enable && !trig) begin
         prev       <= Sample;
         prev_valid <= 1'b1;
      end
   end
`else
   logic unused_thr;
   assign trig       = 1'b0;
   assign unused_thr = ^Threshold;
`endif
   // next state, buffer write enable and completion pulse
   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      done_nxt  = 1'b0;
      if (Abort) state_nxt = IDLE;
      else case (state)
         IDLE:      state_nxt = arm_ok ? ARM_STATE : IDLE;
         WAIT_TRIG: begin
            we        = trig;
            state_nxt = trig ? CAPTURE : WAIT_TRIG;
         end
         CAPTURE:   begin
            we        = Enable;
            state_nxt = (Enable && wr_last) ? DRAIN : CAPTURE;
         end
         DRAIN:     begin
            done_nxt  = xfer & Out_last;
            state_nxt = done_nxt ? IDLE : DRAIN;
         end
         default:   state_nxt = IDLE;
      endcase
   end
   // state, pointers, latched mode and the sticky primed flag
   always_ff @(posedge Fg_CLK) begin
      if (RESET) begin
         state    <= IDLE;
         primed   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         Cap_mode <= '0;
         Done     <= 1'b0;
      end else begin
         state  <= state_nxt;
         Done   <= done_nxt;
         primed <= primed | Ready;
         if (Abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (state == IDLE && arm_ok) begin
               Cap_mode <= Mode;
               wr_ptr   <= '0;
               rd_ptr   <= '0;
            end
            if (we) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (xfer) rd_ptr <= rd_ptr + ADDR_W'(1);
         end
      end
   end
   // sample buffer, deliberately left unreset
   always_ff @(posedge Fg_CLK) begin
      if (we && !RESET) mem[wr_ptr] <= Sample;
   end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: vector table, directed capture/drain/abort sequences and random traffic against a queue-based model
module tb_capture_sequencer;
   logic Fg_CLK = 1'b0;
   logic RESET, Ready, Enable, Arm, Abort, Out_ready;
   logic Busy, Done, Out_valid, Out_last;
   logic [3:0] Mode, Cap_mode;
   logic [7:0] Sample, Threshold, Out_data;
   int errs = 0, checks = 0;

   always #5 Fg_CLK = ~Fg_CLK;

   capture_sequencer #(.DATA_W(8), .ADDR_W(6)) dut (
      .Fg_CLK(Fg_CLK), .RESET(RESET), .Ready(Ready), .Enable(Enable), .Mode(Mode),
      .Sample(Sample), .Arm(Arm), .Abort(Abort), .Threshold(Threshold), .Busy(Busy),
      .Done(Done), .Cap_mode(Cap_mode), .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Out_data(Out_data), .Out_last(Out_last));

   // model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 draining
   bit m_primed, m_done, m_prevv;
   int m_phase, m_rd;
   logic [7:0] m_q[$];
   logic [3:0] m_mode;
   logic [7:0] m_prev;
   logic [7:0] sent[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_primed = 0; m_done = 0; m_prevv = 0; m_phase = 0; m_rd = 0;
      m_q.delete(); m_mode = 0; m_prev = 0;
   endtask

   task automatic model_check();
      chk("busy", 32'(Busy), 32'(m_phase != 0));
      chk("out_valid", 32'(Out_valid), 32'(m_phase == 3));
      chk("out_data", 32'(Out_data), m_phase == 3 ? 32'(m_q[m_rd]) : 32'h0);
      chk("out_last", 32'(Out_last), 32'(m_phase == 3 && m_rd == 63));
      chk("done", 32'(Done), 32'(m_done));
      chk("cap_mode", 32'(Cap_mode), 32'(m_mode));
   endtask

   task automatic model_step();
      bit nd = 0;
      if (RESET) begin
         model_reset();
         return;
      end
      if (Abort) begin
         m_phase = 0; m_q.delete(); m_rd = 0;
      end else if (m_phase == 0) begin
         if (Arm && m_primed) begin
            m_mode = Mode; m_q.delete(); m_rd = 0; m_prevv = 0;
`ifdef CAPTURE_TRIG_EN
            m_phase = 1;
`else
            m_phase = 2;
`endif
         end
      end else if (m_phase == 1) begin
         if (Enable) begin
            if (m_prevv && m_prev < Threshold && Sample >= Threshold) begin
               m_q = {Sample}; m_phase = 2;
            end else begin
               m_prev = Sample; m_prevv = 1;
            end
         end
      end else if (m_phase == 2) begin
         if (Enable) begin
            m_q.push_back(Sample);
            if (m_q.size() == 64) begin m_phase = 3; m_rd = 0; end
         end
      end else if (Out_ready) begin
         if (m_rd == 63) begin m_phase = 0; nd = 1; m_rd = 0; end
         else m_rd++;
      end
      m_primed = m_primed | Ready;
      m_done = nd;
   endtask

   task automatic cyc();
      #1 model_check();
      model_step();
      @(posedge Fg_CLK);
      @(negedge Fg_CLK);
   endtask

   task automatic idle_in();
      RESET = 0; Ready = 0; Enable = 0; Arm = 0; Abort = 0; Out_ready = 0;
      Mode = 0; Sample = 0;
   endtask

   task automatic drain_check(input bit toggle);
      logic [7:0] got[$];
      logic [7:0] held = '0;
      bit lastx = 0, hold = 0, seen = 0;
      Out_ready = 0;
      for (int n = 0; n < 1000 && !seen; n++) begin
         if (Done) begin
            seen = 1;
            chk("done_after_last", 32'(lastx), 32'h1);
         end else begin
            if (hold) chk("hold_data", 32'(Out_data), 32'(held));
            Out_ready = toggle ? ~Out_ready : 1'b1;
            Arm = (n < 3); Enable = 1; Sample = 8'($urandom);
            if (Out_valid && Out_ready) begin
               got.push_back(Out_data);
               chk("last_position", 32'(Out_last), 32'(got.size() == 64));
            end
            lastx = Out_valid & Out_ready & Out_last;
            hold = Out_valid & ~Out_ready;
            held = Out_data;
            cyc();
         end
      end
      if (!seen) chk("done_timeout", 32'h0, 32'h1);
      chk("word_count", 32'(got.size()), 32'd64);
      for (int i = 0; i < got.size() && i < sent.size(); i++) chk("word", 32'(got[i]), 32'(sent[i]));
      Arm = 0; Enable = 0; Out_ready = 0;
   endtask

   task automatic rearm_in_done();
      Arm = 1; Mode = 4'd2;
      cyc();
      chk("rearm_busy", 32'(Busy), 32'h1);
      chk("rearm_mode", 32'(Cap_mode), 32'h2);
      Arm = 0; Abort = 1;
      cyc();
      Abort = 0;
      chk("cleanup_busy", 32'(Busy), 32'h0);
   endtask

   task automatic run_capture(input int period, input bit toggle, input bit ramp);
      int guard = 0;
      Ready = 1; cyc(); Ready = 0;
      Mode = 4'(period == 1 ? 0 : 3); Arm = 1; Enable = 1; Sample = 8'hAA;
      cyc();
      chk("arm_busy", 32'(Busy), 32'h1);
      chk("arm_mode", 32'(Cap_mode), 32'(period == 1 ? 0 : 3));
      sent.delete();
      for (int k = 0; sent.size() < 64 && guard < 5000; k++) begin
         guard++;
         Enable = (k % period == 0);
         Sample = ramp ? 8'(sent.size()) : 8'($urandom);
         if (Enable) sent.push_back(Sample);
         cyc();
      end
      drain_check(toggle);
      rearm_in_done();
   endtask

   typedef struct {bit rst, rdy, arm, abt; logic [3:0] mode; bit busy; logic [3:0] cmode;} vec_t;
   vec_t tv[8];

   initial begin
      idle_in(); Threshold = 8'h80; RESET = 1;
      @(negedge Fg_CLK); @(negedge Fg_CLK);
      model_reset();
      tv[0] = '{1, 0, 0, 0, 4'd0, 0, 4'd0};
      tv[1] = '{0, 0, 1, 0, 4'd3, 0, 4'd0};
      tv[2] = '{0, 1, 1, 0, 4'd2, 0, 4'd0};
      tv[3] = '{0, 0, 1, 0, 4'd4, 1, 4'd4};
      tv[4] = '{0, 0, 0, 1, 4'd0, 0, 4'd4};
      tv[5] = '{0, 0, 1, 1, 4'd1, 0, 4'd4};
      tv[6] = '{1, 0, 0, 0, 4'd0, 0, 4'd0};
      tv[7] = '{0, 0, 1, 0, 4'd2, 0, 4'd0};
      for (int i = 0; i < 8; i++) begin
         RESET = tv[i].rst; Ready = tv[i].rdy; Arm = tv[i].arm; Abort = tv[i].abt; Mode = tv[i].mode;
         cyc();
         chk($sformatf("tv%0d_busy", i), 32'(Busy), 32'(tv[i].busy));
         chk($sformatf("tv%0d_cap_mode", i), 32'(Cap_mode), 32'(tv[i].cmode));
      end
      idle_in();
`ifndef CAPTURE_TRIG_EN
      run_capture(1, 0, 1);
      run_capture(10, 1, 0);
      Arm = 1; cyc(); Arm = 0; Enable = 1;
      for (int i = 0; i < 20; i++) begin Sample = 8'($urandom); cyc(); end
      Abort = 1; cyc(); Abort = 0; Enable = 0;
      chk("abort_cap_busy", 32'(Busy), 32'h0);
      chk("abort_cap_valid", 32'(Out_valid), 32'h0);
      chk("abort_cap_done", 32'(Done), 32'h0);
      cyc();
      chk("abort_cap_done2", 32'(Done), 32'h0);
      Arm = 1; cyc(); Arm = 0; Enable = 1;
      for (int i = 0; i < 64; i++) begin Sample = 8'($urandom); cyc(); end
      Enable = 0; Out_ready = 1;
      for (int i = 0; i < 5; i++) cyc();
      chk("drain_rd5_valid", 32'(Out_valid), 32'h1);
      Abort = 1; Out_ready = 0; cyc(); Abort = 0;
      chk("abort_drn_busy", 32'(Busy), 32'h0);
      chk("abort_drn_valid", 32'(Out_valid), 32'h0);
      chk("abort_drn_done", 32'(Done), 32'h0);
      cyc();
      chk("abort_drn_done2", 32'(Done), 32'h0);
`else
      Ready = 1; cyc(); Ready = 0;
      Threshold = 8'h80; Arm = 1; cyc(); Arm = 0;
      Enable = 1;
      Sample = 8'h90; cyc();
      chk("trig_no_first", 32'(Busy), 32'h1);
      Sample = 8'h70; cyc();
      Sample = 8'h85; cyc();
      sent = {8'h85};
      for (int i = 0; i < 63; i++) begin
         Sample = 8'($urandom); sent.push_back(Sample); cyc();
      end
      Enable = 0;
      drain_check(0);
      rearm_in_done();
`endif
      for (int i = 0; i < 6000; i++) begin
         if (i % 500 == 0) Threshold = 8'($urandom);
         RESET = ($urandom_range(0, 999) == 0);
         Abort = ($urandom_range(0, 399) == 0);
         Ready = ($urandom_range(0, 49) == 0);
         Arm = ($urandom_range(0, 7) == 0);
         Enable = $urandom_range(0, 1) == 1;
         Mode = 4'($urandom_range(0, 4));
         Sample = 8'($urandom);
         Out_ready = $urandom_range(0, 1) == 1;
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one-shot sample captures from the DDS datapath. It arms on request and stores 2^ADDR_W consecutive samples, one on each `Enable` strobe from the sampling controller, into an internal buffer. It then drains the buffer through a valid/ready stream to the display/readout side. The block sits between the sampling controller (`Ready`, `Enable`, `Mode`) and the downstream consumer.

## Interface
- `DATA_W`, default 8: sample width.
- `ADDR_W`, default 6: buffer address width. Depth is 2^ADDR_W (64).
- `Fg_CLK`  in  1  system clock. All logic is on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `Ready`  in  1  single-cycle datapath-ready pulse from the sampling controller.
- `Enable`  in  1  sample strobe, one cycle wide.
- `Mode`  in  4  current decimation mode, 0–4.
- `Sample`  in  DATA_W  datapath sample, valid when `Enable`=1.
- `Arm`  in  1  capture request, level-sampled each cycle.
- `Abort`  in  1  cancels any capture or drain in progress.
- `Threshold`  in  DATA_W  trigger level. Used only with `CAPTURE_TRIG_EN`.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Done`  out  1  one-cycle pulse after the last drained word.
- `Cap_mode`  out  4  `Mode` latched when `Arm` is accepted.
- `Out_valid`  out  1  stream valid.
- `Out_ready`  in  1  stream ready.
- `Out_data`  out  DATA_W  `buf[rd_ptr]`.
- `Out_last`  out  1  high with the final word (rd_ptr = 2^ADDR_W−1).

## Operation
- Reset clears: state=IDLE, `primed`=0, wr_ptr=0, rd_ptr=0, `Busy`=0, `Done`=0, `Cap_mode`=0, `Out_valid`=0, `Out_last`=0, `Out_data`=0. Buffer contents are not reset.
- `primed` is a sticky register, set on the first `Ready` pulse and cleared only by `RESET`.
- States: IDLE, WAIT_TRIG, CAPTURE, DRAIN.
- IDLE:
  - `Arm`=1 with `primed`=1: latch `Cap_mode`←`Mode`, clear wr_ptr, go to WAIT_TRIG (macro defined) or CAPTURE (macro undefined).
  - `Arm` with `primed`=0 is ignored.
  - `Arm` in the same cycle as the first `Ready` is ignored, because `primed` is not yet set.
- WAIT_TRIG: see Configuration.
- CAPTURE:
  - On each cycle with `Enable`=1: `buf[wr_ptr]`←`Sample`, then wr_ptr increments.
  - The write at wr_ptr = 2^ADDR_W−1 moves the block to DRAIN with rd_ptr=0. wr_ptr wraps to 0 and is never used past the end.
  - Cycles with `Enable`=0 change nothing.
- DRAIN:
  - `Out_valid`=1 and `Out_data`=`buf[rd_ptr]` (combinational array read).
  - A transfer is `Out_valid`&`Out_ready`; each transfer increments rd_ptr.
  - The transfer with `Out_last`=1 moves the block to IDLE and pulses `Done`.
  - `Out_data` is held stable while `Out_ready`=0.
  - `Enable` is ignored in this state, so no overwrite occurs.
- `Arm` is ignored in every state except IDLE.
- `Abort`=1 in any state: IDLE next cycle, pointers cleared, `Out_valid`=0, no `Done`.
- Priority within a cycle: `RESET` > `Abort` > all other inputs.
- Counter widths: wr_ptr and rd_ptr are ADDR_W bits. Terminal detection compares against all-ones.

## Timing
- `Arm` accepted at edge N: `Busy`=1 from cycle N+1.
- The first sample eligible for capture is an `Enable` at cycle N+1 or later. An `Enable` coincident with `Arm` is not stored.
- Capture duration is 2^ADDR_W `Enable` strobes. With `Enable` every cycle (Mode 0), DRAIN begins 64 cycles after entry to CAPTURE.
- `Out_valid` rises in the first DRAIN cycle. With `Out_ready` held high, drain takes 64 cycles.
- `Done`=1 for exactly one cycle, the cycle after the final transfer, coincident with state=IDLE and `Busy`=0.
- A new `Arm` may be accepted in the same cycle as that `Done` pulse.

## Configuration
- `CAPTURE_TRIG_EN` defined: WAIT_TRIG is active.
  - On entry, `prev_valid` is cleared.
  - On each `Enable`: if `prev_valid` & (`prev` < `Threshold`) & (`Sample` ≥ `Threshold`), write `Sample` to `buf[0]`, set wr_ptr=1, and go to CAPTURE.
  - Otherwise `prev`←`Sample` and `prev_valid`←1.
  - Comparisons are unsigned.
- `CAPTURE_TRIG_EN` undefined: WAIT_TRIG and `Threshold` logic are absent. IDLE goes directly to CAPTURE on `Arm`.

## Test plan
- Reset, no `Ready`, pulse `Arm` → `Busy` stays 0. After one `Ready` pulse, `Arm` → `Busy`=1 the next cycle and `Cap_mode`=`Mode`.
- Macro off, `Enable` every cycle, `Sample` = ramp 0,1,2… starting the cycle after `Arm`, `Out_ready`=1 → stream 0..63, `Out_last` only on 63, `Done` one cycle after it.
- `Enable` every 10th cycle, `Out_ready` toggling 1/0 → exactly 64 words stored, no duplicates or drops, and `Out_data` held while `Out_ready`=0.
- Macro on, `Threshold`=0x80, samples 0x90, 0x70, 0x85, … → trigger on 0x85. The first sample 0x90 does not trigger. `buf[0]`=0x85.
- `Abort` mid-CAPTURE (wr_ptr=20) and mid-DRAIN (rd_ptr=5) → IDLE the next cycle, `Busy`=0, `Out_valid`=0, no `Done`.
- `Arm` asserted during CAPTURE and DRAIN → ignored. `Arm` in the `Done` cycle → new capture starts.
